exec_stage: RTL and testbench
=============================

Name: exec_stage

Overview:
- Execute stage of the 5-stage RV32I pipeline. Sits directly downstream of the D/E pipeline register and consumes its E-stage outputs.
- Applies operand forwarding, computes the ALU result, and resolves branches/jumps, driving the PC redirect to fetch.
- Registers the results into the E/M pipeline boundary for the memory stage.

Parameters:
- XLEN, 32, datapath width.
- RST_PC, 32'h0000_0000, reset value of PCPlus4M.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- holdM  in  1  freeze E/M register (memory-stage stall).
- ALUSrcE, luiE, regWriteE, memWriteE  in  1 each  E-stage controls.
- RD1E, RD2E, PCE, PCPlus4E, extImmE  in  XLEN each  E-stage data.
- RdE  in  5  destination register.
- branchE, ALUControlE  in  3 each  branch type, ALU op.
- jumpE, resultSrcE  in  2 each  jump type, writeback select.
- forwardAE, forwardBE  in  2 each  forwarding selects from the hazard unit.
- resultW, ALUResultFwdM  in  XLEN each  forwarded values.
- PCSrcE  out  1  redirect fetch (combinational).
- PCTargetE  out  XLEN  redirect target (combinational).
- ALUResultM, writeDataM, PCPlus4M  out  XLEN each  registered.
- RdM  out  5  registered destination.
- regWriteM, memWriteM  out  1 each  registered controls.
- resultSrcM  out  2  registered writeback select.

Behaviour:
- Forwarding mux (A uses RD1E, B uses RD2E): 00 = RDxE, 01 = resultW, 10 = ALUResultFwdM, 11 = RDxE.
- srcA = forwarded A. srcB = extImmE if ALUSrcE, else forwarded B. writeData = forwarded B.
- ALUControlE:
  - 000 add, 001 sub, 010 and, 011 or, 100 xor.
  - 101 slt (signed), 110 sltu; both produce a zero-extended 1-bit result.
  - 111 sll using srcB[4:0].
- luiE=1 overrides the ALU result with extImmE. Arithmetic wraps mod 2^XLEN; no overflow flag.
- branchE (compares forwarded A vs forwarded B):
  - 000 none, 001 beq, 010 bne, 011 blt, 100 bge, 101 bltu, 110 bgeu.
  - 111 reserved, never taken.
- jumpE:
  - 01 jal: target = PCE + extImmE.
  - 10 jalr: target = (forwarded A + extImmE) & ~1.
  - 00 and 11: no jump.
- Target selection: for a branch or no jump, PCTargetE = PCE + extImmE; for jalr, the jalr target.
- PCSrcE = branch taken OR jumpE in {01, 10}. It is purely combinational and asserts in the same cycle the instruction occupies E.
- A jump overrides any branch field. A branch and a jump together are treated as the jump.
- E/M register, on the rising clk edge:
  - holdM=0: capture ALU result, writeData, PCPlus4E, RdE, regWriteE, memWriteE, resultSrcE.
  - holdM=1: all M outputs keep their value.
  - Latency is 1 cycle from E inputs to M outputs.
- Reset (rst_n=0, asynchronous): ALUResultM = 0, writeDataM = 0, PCPlus4M = RST_PC, RdM = 0, regWriteM = 0, memWriteM = 0, resultSrcM = 00.
  - Reset is released synchronously in the sense that the first capture happens at the first edge with rst_n=1.
  - Reset mid-stall clears the registers regardless of holdM.
- Bubbles: an instruction flushed upstream arrives with regWriteE=0 and memWriteE=0 and propagates unchanged. This block does not gate PCSrcE on bubbles; a bubble carries branchE=000 and jumpE=00.

Optional Feature:
- Macro: EXEC_BRANCH_STATS_EN.
- When defined, adds outputs brCountM (32) and brTakenCountM (32).
  - brCountM increments on each edge where holdM=0 and branchE is in 001..110.
  - brTakenCountM increments when that branch is also taken.
  - Both counters wrap at 2^32 and reset to 0.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset: rst_n=0 mid-run with holdM=1 → all M outputs are reset values immediately, without waiting for a clock edge; PCPlus4M = RST_PC.
- ALU path: RD1E=5, RD2E=7, ALUControlE=001, forward 00/00 → next edge ALUResultM = 32'hFFFF_FFFE. With ALUControlE=101 → ALUResultM = 1; with 110 → ALUResultM = 1.
- Forwarding: forwardAE=10, ALUResultFwdM=100, extImmE=-4, ALUSrcE=1, add → ALUResultM = 96. forwardBE=01, resultW=0xAB, memWriteE=1 → writeDataM = 0xAB.
- Branch: blt with A=-1, B=0, PCE=0x100, extImmE=0x20 → PCSrcE=1, PCTargetE=0x120. bltu with the same operands → PCSrcE=0.
- jalr: A=0x2003, extImmE=4, jumpE=10, branchE=001 with A≠B → PCSrcE=1, PCTargetE=0x2006. ALUResultM = PCPlus4M path unaffected.
- Hold: holdM=1 for 3 cycles while E inputs change → M outputs stable. Release → capture on the next edge. With EXEC_BRANCH_STATS_EN, a held branch is not counted.

Source files
------------

// File: rtl/exec_stage.sv
`default_nettype none
// ============================================================================
// Module      : exec_stage
// Description : RV32I execute stage. Operand forwarding, ALU, branch/jump
//               resolution with combinational PC redirect, and the E/M
//               pipeline register feeding the memory stage.
//               Optional macro EXEC_BRANCH_STATS_EN adds branch counters
//               (brCountM, brTakenCountM).
// Revision    : 1.0 - initial release
// ============================================================================
module exec_stage #(
  parameter int              XLEN   = 32,
  parameter logic [XLEN-1:0] RST_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            holdM,
  input  logic            ALUSrcE,
  input  logic            luiE,
  input  logic            regWriteE,
  input  logic            memWriteE,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [XLEN-1:0] extImmE,
  input  logic [4:0]      RdE,
  input  logic [2:0]      branchE,
  input  logic [2:0]      ALUControlE,
  input  logic [1:0]      jumpE,
  input  logic [1:0]      resultSrcE,
  input  logic [1:0]      forwardAE,
  input  logic [1:0]      forwardBE,
  input  logic [XLEN-1:0] resultW,
  input  logic [XLEN-1:0] ALUResultFwdM,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] writeDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [4:0]      RdM,
  output logic            regWriteM,
  output logic            memWriteM,
  output logic [1:0]      resultSrcM
`ifdef EXEC_BRANCH_STATS_EN
  ,
  output logic [31:0]     brCountM,
  output logic [31:0]     brTakenCountM
`endif
);

  localparam logic [2:0] c_ALU_ADD  = 3'b000;
  localparam logic [2:0] c_ALU_SUB  = 3'b001;
  localparam logic [2:0] c_ALU_AND  = 3'b010;
  localparam logic [2:0] c_ALU_OR   = 3'b011;
  localparam logic [2:0] c_ALU_XOR  = 3'b100;
  localparam logic [2:0] c_ALU_SLT  = 3'b101;
  localparam logic [2:0] c_ALU_SLTU = 3'b110;

  localparam logic [2:0] c_BR_BEQ  = 3'b001;
  localparam logic [2:0] c_BR_BNE  = 3'b010;
  localparam logic [2:0] c_BR_BLT  = 3'b011;
  localparam logic [2:0] c_BR_BGE  = 3'b100;
  localparam logic [2:0] c_BR_BLTU = 3'b101;
  localparam logic [2:0] c_BR_BGEU = 3'b110;

  localparam logic [1:0] c_J_JAL  = 2'b01;
  localparam logic [1:0] c_J_JALR = 2'b10;

  logic [XLEN-1:0] w_fwd_a;
  logic [XLEN-1:0] w_fwd_b;
  logic [XLEN-1:0] w_src_b;
  logic [XLEN-1:0] w_alu;
  logic [XLEN-1:0] w_alu_result;
  logic [XLEN-1:0] w_jalr_sum;
  logic            w_eq;
  logic            w_lt;
  logic            w_ltu;
  logic            w_br_taken;
  logic            w_is_jump;

  // Forwarding selects: 01 = writeback value, 10 = memory-stage ALU result
  always_comb begin
    w_fwd_a = RD1E;
    w_fwd_b = RD2E;
    case (forwardAE)
      2'b01:   w_fwd_a = resultW;
      2'b10:   w_fwd_a = ALUResultFwdM;
      default: w_fwd_a = RD1E;
    endcase
    case (forwardBE)
      2'b01:   w_fwd_b = resultW;
      2'b10:   w_fwd_b = ALUResultFwdM;
      default: w_fwd_b = RD2E;
    endcase
  end

  assign w_src_b = ALUSrcE ? extImmE : w_fwd_b;

  // ALU; set-less-than results are zero-extended single bits
  always_comb begin
    w_alu = '0;
    case (ALUControlE)
      c_ALU_ADD:  w_alu = w_fwd_a + w_src_b;
      c_ALU_SUB:  w_alu = w_fwd_a - w_src_b;
      c_ALU_AND:  w_alu = w_fwd_a & w_src_b;
      c_ALU_OR:   w_alu = w_fwd_a | w_src_b;
      c_ALU_XOR:  w_alu = w_fwd_a ^ w_src_b;
      c_ALU_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(w_fwd_a) < $signed(w_src_b))};
      c_ALU_SLTU: w_alu = {{(XLEN-1){1'b0}}, (w_fwd_a < w_src_b)};
      default:    w_alu = w_fwd_a << w_src_b[4:0];
    endcase
  end

  assign w_alu_result = luiE ? extImmE : w_alu;

  // Branch comparisons always use the forwarded register operands, never the immediate
  assign w_eq  = (w_fwd_a == w_fwd_b);
  assign w_lt  = ($signed(w_fwd_a) < $signed(w_fwd_b));
  assign w_ltu = (w_fwd_a < w_fwd_b);

  // Branch condition evaluation; 000 and the reserved 111 are never taken
  always_comb begin
    w_br_taken = 1'b0;
    case (branchE)
      c_BR_BEQ:  w_br_taken = w_eq;
      c_BR_BNE:  w_br_taken = !w_eq;
      c_BR_BLT:  w_br_taken = w_lt;
      c_BR_BGE:  w_br_taken = !w_lt;
      c_BR_BLTU: w_br_taken = w_ltu;
      c_BR_BGEU: w_br_taken = !w_ltu;
      default:   w_br_taken = 1'b0;
    endcase
  end

  // A jump dominates: target follows the jump type and redirect is forced
  assign w_is_jump  = (jumpE == c_J_JAL) || (jumpE == c_J_JALR);
  assign w_jalr_sum = w_fwd_a + extImmE;
  assign PCTargetE  = (jumpE == c_J_JALR) ? {w_jalr_sum[XLEN-1:1], 1'b0} : (PCE + extImmE);
  assign PCSrcE     = w_is_jump || w_br_taken;

  // E/M pipeline register; holdM freezes every field
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALUResultM <= '0;
      writeDataM <= '0;
      PCPlus4M   <= RST_PC;
      RdM        <= '0;
      regWriteM  <= 1'b0;
      memWriteM  <= 1'b0;
      resultSrcM <= 2'b00;
    end else if (!holdM) begin
      ALUResultM <= w_alu_result;
      writeDataM <= w_fwd_b;
      PCPlus4M   <= PCPlus4E;
      RdM        <= RdE;
      regWriteM  <= regWriteE;
      memWriteM  <= memWriteE;
      resultSrcM <= resultSrcE;
    end
  end

`ifdef EXEC_BRANCH_STATS_EN
  logic w_is_branch;
  assign w_is_branch = (branchE != 3'b000) && (branchE != 3'b111);

  // Branch statistics: counted only on edges where the instruction advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brCountM      <= '0;
      brTakenCountM <= '0;
    end else if (!holdM && w_is_branch) begin
      brCountM <= brCountM + 32'd1;
      if (w_br_taken) begin
        brTakenCountM <= brTakenCountM + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_exec_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_exec_stage
// Description : Directed self-checking bench for exec_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_stage;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            holdM;
  logic            ALUSrcE, luiE, regWriteE, memWriteE;
  logic [XLEN-1:0] RD1E, RD2E, PCE, PCPlus4E, extImmE;
  logic [4:0]      RdE;
  logic [2:0]      branchE, ALUControlE;
  logic [1:0]      jumpE, resultSrcE, forwardAE, forwardBE;
  logic [XLEN-1:0] resultW, ALUResultFwdM;
  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE, ALUResultM, writeDataM, PCPlus4M;
  logic [4:0]      RdM;
  logic            regWriteM, memWriteM;
  logic [1:0]      resultSrcM;
`ifdef EXEC_BRANCH_STATS_EN
  logic [31:0]     brCountM, brTakenCountM;
`endif

  int checks = 0;
  int errors = 0;

  exec_stage #(.XLEN(XLEN), .RST_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .holdM(holdM),
    .ALUSrcE(ALUSrcE), .luiE(luiE), .regWriteE(regWriteE), .memWriteE(memWriteE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .extImmE(extImmE),
    .RdE(RdE), .branchE(branchE), .ALUControlE(ALUControlE),
    .jumpE(jumpE), .resultSrcE(resultSrcE), .forwardAE(forwardAE), .forwardBE(forwardBE),
    .resultW(resultW), .ALUResultFwdM(ALUResultFwdM),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .ALUResultM(ALUResultM), .writeDataM(writeDataM), .PCPlus4M(PCPlus4M),
    .RdM(RdM), .regWriteM(regWriteM), .memWriteM(memWriteM), .resultSrcM(resultSrcM)
`ifdef EXEC_BRANCH_STATS_EN
    , .brCountM(brCountM), .brTakenCountM(brTakenCountM)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_defaults();
    holdM = 0; ALUSrcE = 0; luiE = 0; regWriteE = 0; memWriteE = 0;
    RD1E = '0; RD2E = '0; PCE = '0; PCPlus4E = '0; extImmE = '0;
    RdE = '0; branchE = '0; ALUControlE = '0; jumpE = '0; resultSrcE = '0;
    forwardAE = '0; forwardBE = '0; resultW = '0; ALUResultFwdM = '0;
  endtask

  // Advance one edge and settle past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_defaults();
    rst_n = 0;
    #2;
    checks++;
    if (ALUResultM !== 32'h0 || writeDataM !== 32'h0 || PCPlus4M !== 32'h0 ||
        RdM !== 5'd0 || regWriteM !== 1'b0 || memWriteM !== 1'b0 || resultSrcM !== 2'b00) begin
      errors++;
      $display("FAIL reset_initial: alu=%h wd=%h pc4=%h rd=%0d rw=%b mw=%b rs=%b required all zero",
               ALUResultM, writeDataM, PCPlus4M, RdM, regWriteM, memWriteM, resultSrcM);
    end
    @(negedge clk);
    rst_n = 1;
    step();
    // Load non-reset values, then freeze and reset asynchronously
    RD1E = 32'd3; RD2E = 32'd4; PCPlus4E = 32'h44; RdE = 5'd9; regWriteE = 1;
    memWriteE = 1; resultSrcE = 2'b10;
    step();
    checks++;
    if (ALUResultM !== 32'd7 || PCPlus4M !== 32'h44 || RdM !== 5'd9 || resultSrcM !== 2'b10) begin
      errors++;
      $display("FAIL reset_preload: alu=%h pc4=%h rd=%0d rs=%b required 7/44/9/10",
               ALUResultM, PCPlus4M, RdM, resultSrcM);
    end
    holdM = 1;
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    checks++;
    if (ALUResultM !== 32'h0 || writeDataM !== 32'h0 || PCPlus4M !== 32'h0 ||
        RdM !== 5'd0 || regWriteM !== 1'b0 || memWriteM !== 1'b0 || resultSrcM !== 2'b00) begin
      errors++;
      $display("FAIL reset_async_held: alu=%h wd=%h pc4=%h rd=%0d rw=%b mw=%b rs=%b required reset values",
               ALUResultM, writeDataM, PCPlus4M, RdM, regWriteM, memWriteM, resultSrcM);
    end
`ifdef EXEC_BRANCH_STATS_EN
    checks++;
    if (brCountM !== 32'd0 || brTakenCountM !== 32'd0) begin
      errors++;
      $display("FAIL reset_stats: br=%0d taken=%0d required 0/0", brCountM, brTakenCountM);
    end
`endif
    @(negedge clk);
    rst_n = 1;
    drive_defaults();
  endtask

  task automatic test_alu();
    logic [2:0]  ops [8];
    logic [31:0] a   [8];
    logic [31:0] b   [8];
    logic [31:0] exp [8];
    ops = '{3'b001, 3'b101, 3'b110, 3'b010, 3'b011, 3'b100, 3'b111, 3'b101};
    a   = '{32'd5, 32'd5, 32'd5, 32'hF0, 32'hF0, 32'hF0, 32'd1, 32'hFFFF_FFFF};
    b   = '{32'd7, 32'd7, 32'd7, 32'h3C, 32'h3C, 32'h3C, 32'h24, 32'd1};
    exp = '{32'hFFFF_FFFE, 32'd1, 32'd1, 32'h30, 32'hFC, 32'hCC, 32'h10, 32'd1};
    for (int i = 0; i < 8; i++) begin
      drive_defaults();
      RD1E = a[i]; RD2E = b[i]; ALUControlE = ops[i];
      step();
      checks++;
      if (ALUResultM !== exp[i]) begin
        errors++;
        $display("FAIL alu_op%0d: got %h required %h", i, ALUResultM, exp[i]);
      end
    end
    // Unsigned compare of -1 vs 1 is false
    drive_defaults();
    RD1E = 32'hFFFF_FFFF; RD2E = 32'd1; ALUControlE = 3'b110;
    step();
    checks++;
    if (ALUResultM !== 32'd0) begin
      errors++;
      $display("FAIL alu_sltu_neg: got %h required 0", ALUResultM);
    end
    // LUI override
    drive_defaults();
    RD1E = 32'd5; RD2E = 32'd7; luiE = 1; extImmE = 32'h1234_5000;
    step();
    checks++;
    if (ALUResultM !== 32'h1234_5000) begin
      errors++;
      $display("FAIL alu_lui: got %h required 12345000", ALUResultM);
    end
  endtask

  task automatic test_forwarding();
    drive_defaults();
    RD1E = 32'd1; forwardAE = 2'b10; ALUResultFwdM = 32'd100;
    extImmE = 32'hFFFF_FFFC; ALUSrcE = 1;
    RD2E = 32'd2; forwardBE = 2'b01; resultW = 32'hAB; memWriteE = 1;
    step();
    checks++;
    if (ALUResultM !== 32'd96 || writeDataM !== 32'hAB || memWriteM !== 1'b1) begin
      errors++;
      $display("FAIL fwd_m_w: alu=%0d wd=%h mw=%b required 96/ab/1", ALUResultM, writeDataM, memWriteM);
    end
    // Select 11 falls back to the register file values
    drive_defaults();
    RD1E = 32'd10; RD2E = 32'd3; forwardAE = 2'b11; forwardBE = 2'b11;
    resultW = 32'hDEAD; ALUResultFwdM = 32'hBEEF;
    step();
    checks++;
    if (ALUResultM !== 32'd13 || writeDataM !== 32'd3) begin
      errors++;
      $display("FAIL fwd_sel11: alu=%0d wd=%0d required 13/3", ALUResultM, writeDataM);
    end
  endtask

  task automatic test_branch();
    drive_defaults();
    RD1E = 32'hFFFF_FFFF; RD2E = 32'd0; PCE = 32'h100; extImmE = 32'h20; branchE = 3'b011;
    #1;
    checks++;
    if (PCSrcE !== 1'b1 || PCTargetE !== 32'h120) begin
      errors++;
      $display("FAIL br_blt: pcsrc=%b target=%h required 1/120", PCSrcE, PCTargetE);
    end
    branchE = 3'b101;
    #1;
    checks++;
    if (PCSrcE !== 1'b0) begin
      errors++;
      $display("FAIL br_bltu: pcsrc=%b required 0", PCSrcE);
    end
    branchE = 3'b110;
    #1;
    checks++;
    if (PCSrcE !== 1'b1) begin
      errors++;
      $display("FAIL br_bgeu: pcsrc=%b required 1", PCSrcE);
    end
    branchE = 3'b100;
    #1;
    checks++;
    if (PCSrcE !== 1'b0) begin
      errors++;
      $display("FAIL br_bge: pcsrc=%b required 0", PCSrcE);
    end
    RD2E = 32'hFFFF_FFFF; branchE = 3'b001;
    #1;
    checks++;
    if (PCSrcE !== 1'b1) begin
      errors++;
      $display("FAIL br_beq: pcsrc=%b required 1", PCSrcE);
    end
    branchE = 3'b010;
    #1;
    checks++;
    if (PCSrcE !== 1'b0) begin
      errors++;
      $display("FAIL br_bne: pcsrc=%b required 0", PCSrcE);
    end
    branchE = 3'b111;
    #1;
    checks++;
    if (PCSrcE !== 1'b0) begin
      errors++;
      $display("FAIL br_reserved: pcsrc=%b required 0", PCSrcE);
    end
    branchE = 3'b000; jumpE = 2'b11;
    #1;
    checks++;
    if (PCSrcE !== 1'b0 || PCTargetE !== 32'h120) begin
      errors++;
      $display("FAIL jump11: pcsrc=%b target=%h required 0/120", PCSrcE, PCTargetE);
    end
    jumpE = 2'b01;
    #1;
    checks++;
    if (PCSrcE !== 1'b1 || PCTargetE !== 32'h120) begin
      errors++;
      $display("FAIL jal: pcsrc=%b target=%h required 1/120", PCSrcE, PCTargetE);
    end
  endtask

  task automatic test_jalr();
    drive_defaults();
    RD1E = 32'h2003; RD2E = 32'd5; extImmE = 32'd4; jumpE = 2'b10; branchE = 3'b001;
    PCE = 32'h100; PCPlus4E = 32'h104; RdE = 5'd1; regWriteE = 1;
    #1;
    checks++;
    if (PCSrcE !== 1'b1 || PCTargetE !== 32'h2006) begin
      errors++;
      $display("FAIL jalr: pcsrc=%b target=%h required 1/2006", PCSrcE, PCTargetE);
    end
    step();
    checks++;
    if (PCPlus4M !== 32'h104 || ALUResultM !== 32'h2008 || RdM !== 5'd1 || regWriteM !== 1'b1) begin
      errors++;
      $display("FAIL jalr_m: pc4=%h alu=%h rd=%0d rw=%b required 104/2008/1/1",
               PCPlus4M, ALUResultM, RdM, regWriteM);
    end
  endtask

  task automatic test_hold();
    logic [31:0] br0, tk0;
    drive_defaults();
    RD1E = 32'd20; RD2E = 32'd22; PCPlus4E = 32'h204; RdE = 5'd7; regWriteE = 1; resultSrcE = 2'b01;
    step();
    br0 = '0; tk0 = '0;
`ifdef EXEC_BRANCH_STATS_EN
    br0 = brCountM; tk0 = brTakenCountM;
`endif
    holdM = 1;
    for (int i = 0; i < 3; i++) begin
      RD1E = 32'd100 + i; PCPlus4E = 32'h300 + i; RdE = 5'd20 + 5'(i); regWriteE = 0;
      memWriteE = 1; resultSrcE = 2'b11; branchE = 3'b011; RD2E = 32'd500;
      step();
      checks++;
      if (ALUResultM !== 32'd42 || PCPlus4M !== 32'h204 || RdM !== 5'd7 ||
          regWriteM !== 1'b1 || memWriteM !== 1'b0 || resultSrcM !== 2'b01 || writeDataM !== 32'd22) begin
        errors++;
        $display("FAIL hold_cycle%0d: alu=%0d pc4=%h rd=%0d rw=%b mw=%b rs=%b wd=%0d required 42/204/7/1/0/01/22",
                 i, ALUResultM, PCPlus4M, RdM, regWriteM, memWriteM, resultSrcM, writeDataM);
      end
    end
`ifdef EXEC_BRANCH_STATS_EN
    checks++;
    if (brCountM !== br0 || brTakenCountM !== tk0) begin
      errors++;
      $display("FAIL hold_stats: br=%0d taken=%0d required %0d/%0d", brCountM, brTakenCountM, br0, tk0);
    end
`endif
    // Release: the last presented instruction (taken blt) is captured on the next edge
    holdM = 0;
    step();
    branchE = 3'b000;
    checks++;
    if (ALUResultM !== 32'd602 || PCPlus4M !== 32'h302 || RdM !== 5'd22 ||
        regWriteM !== 1'b0 || memWriteM !== 1'b1 || resultSrcM !== 2'b11) begin
      errors++;
      $display("FAIL hold_release: alu=%0d pc4=%h rd=%0d rw=%b mw=%b rs=%b required 602/302/22/0/1/11",
               ALUResultM, PCPlus4M, RdM, regWriteM, memWriteM, resultSrcM);
    end
`ifdef EXEC_BRANCH_STATS_EN
    checks++;
    if (brCountM !== br0 + 32'd1 || brTakenCountM !== tk0 + 32'd1) begin
      errors++;
      $display("FAIL release_stats: br=%0d taken=%0d required %0d/%0d",
               brCountM, brTakenCountM, br0 + 32'd1, tk0 + 32'd1);
    end
`endif
  endtask

  task automatic test_back_to_back();
    // Consecutive instructions each land one edge later
    drive_defaults();
    RD1E = 32'd1; RD2E = 32'd2; RdE = 5'd3;
    step();
    RD1E = 32'd10; RD2E = 32'd20; RdE = 5'd4; ALUControlE = 3'b001;
    checks++;
    if (ALUResultM !== 32'd3 || RdM !== 5'd3) begin
      errors++;
      $display("FAIL b2b_first: alu=%0d rd=%0d required 3/3", ALUResultM, RdM);
    end
    step();
    checks++;
    if (ALUResultM !== 32'hFFFF_FFF6 || RdM !== 5'd4) begin
      errors++;
      $display("FAIL b2b_second: alu=%h rd=%0d required fffffff6/4", ALUResultM, RdM);
    end
  endtask

  initial begin
    rst_n = 0;
    drive_defaults();
    test_reset();
    test_alu();
    test_forwarding();
    test_branch();
    test_jalr();
    test_hold();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
